pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_rs, id_rt  input  5 each  source register numbers of instruction in ID.
REQ-004 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-005 ex_wa, mem_wa, wb_wa  input  5 each  destination register held in ID/EX, EX/MEM, MEM/WB.
REQ-006 ex_we, mem_we, wb_we  input  1 each  that stage writes the register file (WB_Write equivalent).
REQ-007 ex_load  input  1  instruction in ID/EX is a load.
REQ-008 br_taken  input  1  taken branch resolved in EX/MEM (cond).
REQ-009 pc_hold  output  1  freeze PC.
REQ-010 id_hold  output  1  freeze IF/ID.
REQ-011 ex_bubble  output  1  load NOP into ID/EX.
REQ-012 flush  output  1  clear IF/ID, ID/EX and EX/MEM to NOP.
REQ-013 fwd_a, fwd_b  output  2 each  operand select: 0 regfile, 1 EX/MEM ALUo, 2 MEM/WB WB_Data, 3 unused.
REQ-014 state  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
REQ-015 stall_cnt  output  2  remaining stall cycles.

Function
REQ-016 Hazard source valid only when the stage's we=1 and its address is non-zero and equals a used ID source; register 0 never causes a hazard or forward.
REQ-017 Register file writes in first half-cycle; MEM/WB producer never requires a stall.
REQ-018 pc_hold = id_hold = ex_bubble = (state==STALL) or (state==RUN and stall condition detected); all are combinational.
REQ-019 RUN: on detected stall, load stall_cnt with required length minus 1 and go to STALL, unless the length is 1, in which case stay RUN after holding one cycle.
REQ-020 STALL: decrement stall_cnt each cycle; at stall_cnt==0 on a rising edge, return to RUN and re-evaluate hazards next cycle.
REQ-021 br_taken=1 in any state: flush=1 that cycle, stall outputs forced 0, stall_cnt cleared, next state FLUSH.
REQ-022 FLUSH: one cycle; flush=0; hazard detection masked (all stall outputs 0, fwd 0); next state RUN, or FLUSH again if br_taken=1.
REQ-023 br_taken has priority over any stall or stall_cnt value; a branch arriving mid-stall aborts the stall.
REQ-024 Forwarding priority: EX/MEM match over MEM/WB match; fwd_a/fwd_b valid only in RUN and STALL, else 0.
REQ-025 stall_cnt never wraps; decrement saturates at 0.

Reset
REQ-026 rst sampled on rising edge: state=RUN, stall_cnt=0; all outputs 0 the cycle after rst is seen high, and held 0 while rst=1 (including stall and flush outputs).
REQ-027 rst mid-stall or mid-flush abandons the operation with no residual hold.

Configuration
REQ-028 Macro PIPE_FORWARD_EN: defined -> forwarding per REQ-024; stall only for ex_load match with ID source, length 1.
REQ-029 PIPE_FORWARD_EN undefined -> fwd_a = fwd_b = 0 always; stall length 2 for ID/EX producer match, 1 for EX/MEM producer match, none for MEM/WB.

Verification
REQ-030 FWD on: ex_wa=5, ex_we=1, ex_load=0, id_rs=5, id_use_rs=1 -> fwd_a=1, no stall.
REQ-031 FWD on: ex_load=1, ex_wa=8, id_rt=8, id_use_rt=1 -> pc_hold/id_hold/ex_bubble=1 for exactly 1 cycle, then mem_wa=8 gives fwd_b=1.
REQ-032 FWD off: ex_wa=3, ex_we=1, id_rs=3 -> state STALL, stall_cnt 1 then 0, holds for 2 cycles, RUN on third.
REQ-033 br_taken=1 during STALL with stall_cnt=1 -> flush=1 that cycle, holds 0, next state FLUSH, then RUN.
REQ-034 ex_wa=0, ex_we=1, id_rs=0 -> no stall, fwd_a=0 in both configurations.
REQ-035 rst=1 asserted in STALL -> next cycle state=0, stall_cnt=0, all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/RAW stall, branch flush and operand forwarding control.
// Define PIPE_FORWARD_EN to enable forwarding (only load-use stalls remain).
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_wa,
    input  logic [4:0] mem_wa,
    input  logic [4:0] wb_wa,
    input  logic       ex_we,
    input  logic       mem_we,
    input  logic       wb_we,
    input  logic       ex_load,
    input  logic       br_taken,
    output logic       pc_hold,
    output logic       id_hold,
    output logic       ex_bubble,
    output logic       flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] state,
    output logic [1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
    state_t st;
    logic [1:0] cnt;
    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic ex_hit, mem_hit, stall_det, stall_long, hold;
    logic [1:0] fa_raw, fb_raw;

    // Register 0 is hardwired, so it never produces a hazard or forward.
    function automatic logic hit(input logic [4:0] src, input logic use_src,
                                 input logic [4:0] wa, input logic we);
        return use_src && we && (wa != 5'd0) && (src == wa);
    endfunction

    assign a_ex    = hit(id_rs, id_use_rs, ex_wa, ex_we);
    assign a_mem   = hit(id_rs, id_use_rs, mem_wa, mem_we);
    assign a_wb    = hit(id_rs, id_use_rs, wb_wa, wb_we);
    assign b_ex    = hit(id_rt, id_use_rt, ex_wa, ex_we);
    assign b_mem   = hit(id_rt, id_use_rt, mem_wa, mem_we);
    assign b_wb    = hit(id_rt, id_use_rt, wb_wa, wb_we);
    assign ex_hit  = a_ex | b_ex;
    assign mem_hit = a_mem | b_mem;

`ifdef PIPE_FORWARD_EN
    logic unused_ok;
    assign unused_ok  = mem_hit;
    assign stall_det  = ex_hit & ex_load;
    assign stall_long = 1'b0;
    assign fa_raw = (a_ex && !ex_load) ? 2'd1 : a_mem ? 2'd1 : a_wb ? 2'd2 : 2'd0;
    assign fb_raw = (b_ex && !ex_load) ? 2'd1 : b_mem ? 2'd1 : b_wb ? 2'd2 : 2'd0;
`else
    // Register file writes in the first half-cycle, so a MEM/WB producer is harmless.
    logic unused_ok;
    assign unused_ok  = &{1'b0, ex_load, a_wb, b_wb};
    assign stall_det  = ex_hit | mem_hit;
    assign stall_long = ex_hit;
    assign fa_raw = 2'd0;
    assign fb_raw = 2'd0;
`endif

    assign hold      = !rst && !br_taken && (st == STALL || (st == RUN && stall_det));
    assign pc_hold   = hold;
    assign id_hold   = hold;
    assign ex_bubble = hold;
    assign flush     = !rst && br_taken;
    assign fwd_a     = (!rst && (st == RUN || st == STALL)) ? fa_raw : 2'd0;
    assign fwd_b     = (!rst && (st == RUN || st == STALL)) ? fb_raw : 2'd0;
    assign state     = st;
    assign stall_cnt = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= RUN;
            cnt <= 2'd0;
        end else if (br_taken) begin
            st  <= FLUSH;
            cnt <= 2'd0;
        end else if (st == STALL) begin
            st  <= (cnt <= 2'd1) ? RUN : STALL;
            cnt <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end else if (st == RUN && stall_long) begin
            st  <= STALL;
            cnt <= 2'd1;
        end else begin
            st  <= RUN;
            cnt <= 2'd0;
        end
    end
endmodule
